// File: rtl/adder_16bit_core_pkg.sv
// Shared definitions for the 16-bit adder slice.
//   ADD_W  : operand/sum width
//   GRP_W  : carry-lookahead group width
//   word_t : one operand or sum word
package adder_pkg;

  localparam int ADD_W = 16;
  localparam int GRP_W = 4;

  typedef logic [ADD_W-1:0] word_t;

endpackage

// File: rtl/adder_16bit_core_if.sv
// Operand/result bundle for adder_16bit_core.
//   in_valid, a, b, cin       : operands, driven by the master
//   out_valid, sum, cout, ovf : registered result, driven by the slave (adder)
interface adder_16bit_core_if;
  import adder_pkg::*;

  logic  in_valid;
  word_t a;
  word_t b;
  logic  cin;
  logic  out_valid;
  word_t sum;
  logic  cout;
  logic  ovf;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_16bit_core_cla_4bit.sv
// 4-bit carry-lookahead adder group.
//   a, b : 4-bit operand slices
//   ci   : group carry-in
//   s    : 4-bit sum slice
//   co   : group carry-out
//   gg   : group generate (carry out regardless of ci)
//   gp   : group propagate (ci passes straight to co)
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is expanded from ci directly, so no carry ripples inside the group.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
  assign co = gg | (gp & ci);

  assign s = p ^ c;

endmodule

// File: rtl/adder_16bit_core.sv
// 16-bit registered adder: sum = a + b + cin, with carry-out and signed overflow.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears result and valid
//   bus   : slave side of adder_16bit_core_if (in_valid/a/b/cin in,
//           out_valid/sum/cout/ovf out, one cycle latency)
module adder_16bit_core
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_W,
  parameter int GROUP = GRP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_16bit_core_if.slave    bus
);

  localparam int NGRP = WIDTH / GROUP;

  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                      input logic signed [WIDTH-1:0] y,
                                      input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic        [NGRP:0]    carry;
  logic signed [WIDTH-1:0] sum_p0;
  logic                    ovf_p0;
  logic        [NGRP-1:0]  grp_g_unused;
  logic        [NGRP-1:0]  grp_p_unused;

  assign carry[0] = bus.cin;

  // Group carries ripple from one lookahead group into the next.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla_4bit u_cla (
      .a  (bus.a[gi*GROUP +: GROUP]),
      .b  (bus.b[gi*GROUP +: GROUP]),
      .ci (carry[gi]),
      .s  (sum_p0[gi*GROUP +: GROUP]),
      .co (carry[gi+1]),
      .gg (grp_g_unused[gi]),
      .gp (grp_p_unused[gi])
    );
  end

  assign ovf_p0 = signed_ovf(bus.a, bus.b, sum_p0);

  // ---- stage p0 -> p1: result registers ----
  logic signed [WIDTH-1:0] sum_p1;
  logic                    cout_p1;
  logic                    ovf_p1;
  logic                    vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      // Data holds while idle so downstream can keep reading the last result.
      if (bus.in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= carry[NGRP];
        ovf_p1  <= ovf_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.sum       = sum_p1;
  assign bus.cout      = cout_p1;
  assign bus.ovf       = ovf_p1;

endmodule

// File: tb/tb_adder_16bit_core.sv
// Directed self-checking bench for adder_16bit_core.
module tb_adder_16bit_core;
  import adder_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  adder_16bit_core_if bus ();

  adder_16bit_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed result packed as {out_valid, cout, ovf, sum}.
  function automatic logic [18:0] obs();
    return {bus.out_valid, bus.cout, bus.ovf, bus.sum};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.a   = 16'h1234;
    bus.b   = 16'h1111;
    bus.cin = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs() !== 19'h0_0000) begin
        bad++;
        $display("FAIL reset_hold cyc%0d got=%h want=%h", i, obs(), 19'h0_0000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    drive(1'b1, 16'h0003, 16'h0005, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b100, 16'h0008}) begin
      bad++;
      $display("FAIL basic_add got=%h want=%h", obs(), {3'b100, 16'h0008});
    end
  endtask

  task automatic test_carry_chain();
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b110, 16'h0000}) begin
      bad++;
      $display("FAIL carry_ffff got=%h want=%h", obs(), {3'b110, 16'h0000});
    end
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b100, 16'h0100}) begin
      bad++;
      $display("FAIL carry_00ff got=%h want=%h", obs(), {3'b100, 16'h0100});
    end
    // FFFF + FFFF + 1 = 1_FFFF; both negative, sum negative -> no overflow.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b110, 16'hFFFF}) begin
      bad++;
      $display("FAIL carry_max got=%h want=%h", obs(), {3'b110, 16'hFFFF});
    end
    // Mid-word carry: 0F0F + 00F1 = 1000
    drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b100, 16'h1000}) begin
      bad++;
      $display("FAIL carry_mid got=%h want=%h", obs(), {3'b100, 16'h1000});
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b101, 16'h8000}) begin
      bad++;
      $display("FAIL ovf_pos got=%h want=%h", obs(), {3'b101, 16'h8000});
    end
    drive(1'b1, 16'h8000, 16'h8000, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b111, 16'h0000}) begin
      bad++;
      $display("FAIL ovf_neg got=%h want=%h", obs(), {3'b111, 16'h0000});
    end
    // Mixed signs never overflow: 8000 + 7FFF = FFFF.
    drive(1'b1, 16'h8000, 16'h7FFF, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b100, 16'hFFFF}) begin
      bad++;
      $display("FAIL ovf_mixed got=%h want=%h", obs(), {3'b100, 16'hFFFF});
    end
  endtask

  logic [15:0] last_sum;

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    logic [16:0] full;
    logic        eovf;
    logic [18:0] want;
    for (int i = 0; i < 250; i++) begin
      ra = 16'(i / 2);
      rb = 16'(i);
      drive(1'b1, ra, rb, 1'b0);
      full = {1'b0, ra} + {1'b0, rb};
      eovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      want = {1'b1, full[16], eovf, full[15:0]};
      @(posedge clk); #1;
      total++;
      if (obs() !== want) begin
        bad++;
        $display("FAIL ramp i=%0d got=%h want=%h", i, obs(), want);
      end
      last_sum = full[15:0];
    end
  endtask

  task automatic test_idle_async_reset();
    // Garbage operands while idle must not reach the result registers.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
      @(posedge clk); #1;
      total++;
      if (obs() !== {3'b000, last_sum}) begin
        bad++;
        $display("FAIL idle_hold cyc%0d got=%h want=%h", i, obs(), {3'b000, last_sum});
      end
    end
    // Load a nonzero result with all flags set, then reset between clock edges.
    drive(1'b1, 16'h8000, 16'h8001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b111, 16'h0001}) begin
      bad++;
      $display("FAIL pre_reset got=%h want=%h", obs(), {3'b111, 16'h0001});
    end
    drive(1'b1, 16'h0001, 16'h0001, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 19'h0_0000) begin
      bad++;
      $display("FAIL async_clear got=%h want=%h", obs(), 19'h0_0000);
    end
    @(posedge clk); #1;
    total++;
    if (obs() !== 19'h0_0000) begin
      bad++;
      $display("FAIL reset_edge got=%h want=%h", obs(), 19'h0_0000);
    end
    // Release with in_valid low: the operand presented during reset never appears.
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs() !== 19'h0_0000) begin
      bad++;
      $display("FAIL discard got=%h want=%h", obs(), 19'h0_0000);
    end
    drive(1'b1, 16'h1234, 16'h1111, 1'b1);
    @(posedge clk); #1;
    total++;
    if (obs() !== {3'b100, 16'h2346}) begin
      bad++;
      $display("FAIL post_reset got=%h want=%h", obs(), {3'b100, 16'h2346});
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    last_sum     = 16'h0000;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.cin      = 1'b0;
    #2;
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_idle_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_16bit_core.md
Name:
adder_16bit_core

Overview:
- 16-bit binary adder with carry-in, carry-out and a signed-overflow flag.
- Results are registered: one clock of latency, qualified by a valid strobe.
- Used as the arithmetic leaf for datapath blocks that need a + b + cin on 16-bit unsigned or two's-complement operands.
- Adder core is four 4-bit carry-lookahead groups, with the carry rippling between groups.

Parameters:
- WIDTH, 16: operand and sum width. Fixed at 16; must be a multiple of 4.
- GROUP, 4: carry-lookahead group width. Fixed at 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and cin valid this cycle.
- a  input  16  operand A.
- b  input  16  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout/ovf hold a fresh result.
- sum  output  16  registered (a + b + cin) mod 2^16.
- cout  output  1  registered carry out of bit 15.
- ovf  output  1  registered signed overflow: (a[15]==b[15]) && (sum[15]!=a[15]).

Behaviour:
- Reset:
  - rst_n low, asynchronously: sum=16'h0000, cout=0, ovf=0, out_valid=0.
  - Outputs are held at these values while rst_n stays low.
  - Release is synchronous in effect: the first capture happens at the first rising clk edge after rst_n goes high.
- Arithmetic (combinational):
  - {cout_c, sum_c} = a + b + cin, 17-bit result.
  - No saturation; wrap-around modulo 2^16.
- Latency:
  - Rising clk with in_valid=1: sum/cout/ovf load the combinational result, out_valid <= 1.
  - Result is visible exactly one cycle after the operands are presented.
- Idle:
  - in_valid=0 at a rising edge: out_valid <= 0.
  - sum/cout/ovf hold their previous values; they are not cleared.
- Back-to-back:
  - in_valid high on consecutive cycles gives one result per cycle.
  - No stall, no backpressure, no ready signal.
- Reset mid-operation: an operand presented in the cycle rst_n asserts is discarded. No result for it ever appears.
- Carry structure:
  - Each group computes g_i = a_i & b_i and p_i = a_i ^ b_i.
  - Group carries use lookahead: c_{i+1} = g_i | p_i & c_i, expanded.
  - Group carry-out feeds the next group's carry-in.
  - Group 0 carry-in = cin; group 3 carry-out = cout.
- Boundary cases:
  - 16'hFFFF + 16'h0000 + cin=1 → sum 0000, cout 1.
  - 16'hFFFF + 16'hFFFF + cin=1 → sum FFFF, cout 1.
  - 16'h7FFF + 16'h0001 → sum 8000, ovf 1, cout 0.
  - 16'h8000 + 16'h8000 → sum 0000, cout 1, ovf 1.
- X-handling: operands are sampled only when in_valid=1. Operands with in_valid=0 must not affect the outputs.

Decomposition:
- Shared package adder_pkg:
  - localparam ADD_W=16 and GRP_W=4.
  - typedef logic [ADD_W-1:0] word_t.
- One sub-module: cla_4bit.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, plus group generate/propagate for future two-level lookahead.
  - Instantiated four times via generate.
- Output registers and the ovf logic live in adder_16bit_core.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, a=1234, b=1111 → sum=0000, cout=0, ovf=0, out_valid=0 throughout.
- Basic add: a=0003, b=0005, cin=0, in_valid=1 → next cycle sum=0008, cout=0, ovf=0, out_valid=1.
- Carry chain: a=FFFF, b=0000, cin=1 → sum=0000, cout=1. Then a=00FF, b=0001, cin=0 → sum=0100, cout=0 on the following cycle.
- Signed overflow: a=7FFF, b=0001 → sum=8000, ovf=1, cout=0. Then a=8000, b=8000 → sum=0000, ovf=1, cout=1.
- Streaming ramp: b increments every cycle and a every 2 cycles from 0000, cin=0, 250 cycles → each out_valid result equals the previous cycle's a+b, compared against a 17-bit scoreboard.
- Idle and async reset: drop in_valid for 2 cycles → out_valid=0 and sum holds. Then pulse rst_n low mid-cycle → outputs clear immediately, without waiting for a clk edge.
